// File: rtl/alu16_seq.sv
// Runs 16-bit ADD HL,rr / INC rr / DEC rr / ADD SP,e8 as two passes over the shared 8-bit ALU; accept->done 3 cycles.
// Backpressure: req_ready only in IDLE, so at most one op per 4 cycles; the requester holds its request until accepted.
package alu16_seq_pkg;
    typedef logic [7:0] data_t;

    typedef struct packed {
        logic z;
        logic n;
        logic h;
        logic c;
    } flags_t;

    typedef enum logic [3:0] {
        ALU_LD1, ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC,
        ALU_AND, ALU_XOR, ALU_OR,  ALU_CP,  ALU_INC, ALU_DEC
    } alu_op_t;

    typedef enum logic [1:0] {
        CMD_ADD16 = 2'd0,
        CMD_INC16 = 2'd1,
        CMD_DEC16 = 2'd2,
        CMD_ADDSP = 2'd3
    } cmd_t;
endpackage

module alu16_seq
    import alu16_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_cmd,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  flags_t      req_flags,
    output logic        alu_own,
    output alu_op_t     alu_op,
    output data_t       alu_op1,
    output data_t       alu_op2,
    output flags_t      alu_in_flags,
    input  data_t       alu_result,
    input  flags_t      alu_out_flags,
    output logic        done,
    output logic [15:0] result,
    output flags_t      out_flags
);

    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    cmd_t        r_cmd;
    logic [15:0] r_a;
    logic [15:0] r_b;
    flags_t      r_flags;
    data_t       r_res_lo;
    flags_t      r_lo_flags;
    logic [15:0] r_result;
    flags_t      r_out_flags;
    flags_t      w_out_flags_nxt;

    // The high-byte pass lands result and flags directly, so they are ready in DONE and hold afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cmd       <= CMD_ADD16;
            r_a         <= '0;
            r_b         <= '0;
            r_flags     <= '0;
            r_res_lo    <= '0;
            r_lo_flags  <= '0;
            r_result    <= '0;
            r_out_flags <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && req_valid) begin
                r_cmd   <= cmd_t'(req_cmd);
                r_a     <= req_a;
                r_b     <= req_b;
                r_flags <= req_flags;
            end
            if (r_state == S_LO) begin
                r_res_lo   <= alu_result;
                r_lo_flags <= alu_out_flags;
            end
            if (r_state == S_HI) begin
                r_result    <= {alu_result, r_res_lo};
                r_out_flags <= w_out_flags_nxt;
            end
        end
    end

    always_comb begin
        w_out_flags_nxt = r_flags;
        unique case (r_cmd)
            CMD_ADD16: w_out_flags_nxt = '{z: r_flags.z, n: 1'b0, h: alu_out_flags.h, c: alu_out_flags.c};
            CMD_ADDSP: w_out_flags_nxt = '{z: 1'b0, n: 1'b0, h: r_lo_flags.h, c: r_lo_flags.c};
            default:   w_out_flags_nxt = r_flags;
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        req_ready    = 1'b0;
        alu_own      = 1'b0;
        alu_op       = ALU_LD1;
        alu_op1      = '0;
        alu_op2      = '0;
        alu_in_flags = '0;
        done         = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_state_nxt = S_LO;
            end
            S_LO: begin
                alu_own     = 1'b1;
                alu_op1     = r_a[7:0];
                w_state_nxt = S_HI;
                unique case (r_cmd)
                    CMD_ADD16: begin alu_op = ALU_ADD; alu_op2 = r_b[7:0]; end
                    CMD_INC16: begin alu_op = ALU_ADD; alu_op2 = 8'h01;    end
                    CMD_DEC16: begin alu_op = ALU_SUB; alu_op2 = 8'h01;    end
                    default:   begin alu_op = ALU_ADD; alu_op2 = r_b[7:0]; end
                endcase
            end
            S_HI: begin
                // Plain ADC/SBC keep the low-byte carry chaining; INC/DEC would drop it.
                alu_own        = 1'b1;
                alu_op1        = r_a[15:8];
                alu_in_flags.c = r_lo_flags.c;
                w_state_nxt    = S_DONE;
                unique case (r_cmd)
                    CMD_ADD16: begin alu_op = ALU_ADC; alu_op2 = r_b[15:8];  end
                    CMD_INC16: begin alu_op = ALU_ADC; alu_op2 = 8'h00;      end
                    CMD_DEC16: begin alu_op = ALU_SBC; alu_op2 = 8'h00;      end
                    default:   begin alu_op = ALU_ADC; alu_op2 = {8{r_b[7]}}; end
                endcase
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign result    = r_result;
    assign out_flags = r_out_flags;

endmodule

// File: tb/tb_alu16_seq.sv
// Directed bench for alu16_seq with a behavioural SM83 8-bit ALU hooked to its ALU ports.
module tb_alu16_seq;
    import alu16_seq_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_cmd;
    logic [15:0] req_a;
    logic [15:0] req_b;
    flags_t      req_flags;
    logic        alu_own;
    alu_op_t     alu_op;
    data_t       alu_op1;
    data_t       alu_op2;
    flags_t      alu_in_flags;
    data_t       alu_result;
    flags_t      alu_out_flags;
    logic        done;
    logic [15:0] result;
    flags_t      out_flags;

    int n_checks = 0;
    int n_errors = 0;

    alu16_seq dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_a(req_a), .req_b(req_b), .req_flags(req_flags),
        .alu_own(alu_own), .alu_op(alu_op), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_in_flags(alu_in_flags), .alu_result(alu_result), .alu_out_flags(alu_out_flags),
        .done(done), .result(result), .out_flags(out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference 8-bit ALU: add/adc/sub/sbc with SM83 half-carry and carry/borrow.
    logic [8:0] m_t;
    logic [4:0] m_h;
    logic       m_ci;
    always_comb begin
        alu_result    = alu_op1;
        alu_out_flags = alu_in_flags;
        m_t  = '0;
        m_h  = '0;
        m_ci = 1'b0;
        case (alu_op)
            ALU_ADD, ALU_ADC: begin
                m_ci = (alu_op == ALU_ADC) ? alu_in_flags.c : 1'b0;
                m_t  = {1'b0, alu_op1} + {1'b0, alu_op2} + {8'd0, m_ci};
                m_h  = {1'b0, alu_op1[3:0]} + {1'b0, alu_op2[3:0]} + {4'd0, m_ci};
                alu_result    = m_t[7:0];
                alu_out_flags = '{z: (m_t[7:0] == 8'h00), n: 1'b0, h: m_h[4], c: m_t[8]};
            end
            ALU_SUB, ALU_SBC: begin
                m_ci = (alu_op == ALU_SBC) ? alu_in_flags.c : 1'b0;
                m_t  = {1'b0, alu_op1} - {1'b0, alu_op2} - {8'd0, m_ci};
                m_h  = {1'b0, alu_op1[3:0]} - {1'b0, alu_op2[3:0]} - {4'd0, m_ci};
                alu_result    = m_t[7:0];
                alu_out_flags = '{z: (m_t[7:0] == 8'h00), n: 1'b1, h: m_h[4], c: m_t[8]};
            end
            default: ;
        endcase
    end

    // Issues one request, waits up to 10 cycles for done, and records what the block drove.
    task automatic run_op(input logic [1:0] cmd, input logic [15:0] a, input logic [15:0] b,
                          input flags_t f, output logic [15:0] res, output flags_t of,
                          output int lat, output logic [7:0] own, output alu_op_t lo_op,
                          output alu_op_t hi_op, output data_t hi_op2, output flags_t hi_in);
        res = '0; of = '0; lat = -1; own = '0;
        lo_op = ALU_LD1; hi_op = ALU_LD1; hi_op2 = '0; hi_in = '0;
        @(negedge clk);
        req_valid = 1'b1; req_cmd = cmd; req_a = a; req_b = b; req_flags = f;
        own[0] = alu_own;
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            if (k < 8) own[k] = alu_own;
            if (k == 1) lo_op = alu_op;
            if (k == 2) begin hi_op = alu_op; hi_op2 = alu_op2; hi_in = alu_in_flags; end
            if (done) begin
                lat = k; res = result; of = out_flags;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL rst_ready: got %b exp 1", req_ready); end
        n_checks++; if (alu_own !== 1'b0) begin n_errors++; $display("FAIL rst_own: got %b exp 0", alu_own); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL rst_done: got %b exp 0", done); end
        n_checks++; if (result !== 16'h0000) begin n_errors++; $display("FAIL rst_result: got %h exp 0000", result); end
        n_checks++; if (out_flags !== 4'b0000) begin n_errors++; $display("FAIL rst_flags: got %b exp 0000", out_flags); end
        n_checks++; if (alu_op !== ALU_LD1 || alu_op1 !== 8'h00 || alu_op2 !== 8'h00 || alu_in_flags !== 4'b0000) begin
            n_errors++; $display("FAIL rst_alu_drive: got op=%0d op1=%h op2=%h cin=%b exp op=%0d zeros", alu_op, alu_op1, alu_op2, alu_in_flags, ALU_LD1);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add16();
        logic [15:0] res; flags_t of; int lat; logic [7:0] own;
        alu_op_t lo_op, hi_op; data_t hi_op2; flags_t hi_in;
        run_op(2'd0, 16'h0FFF, 16'h0001, 4'b1000, res, of, lat, own, lo_op, hi_op, hi_op2, hi_in);
        n_checks++; if (lat !== 3) begin n_errors++; $display("FAIL add16_latency: got %0d exp 3", lat); end
        n_checks++; if (res !== 16'h1000) begin n_errors++; $display("FAIL add16_result: got %h exp 1000", res); end
        n_checks++; if (of !== 4'b1010) begin n_errors++; $display("FAIL add16_flags: got %b exp 1010", of); end
        n_checks++; if (own !== 8'h06) begin n_errors++; $display("FAIL add16_own_cycles: got %b exp 00000110", own); end
        n_checks++; if (lo_op !== ALU_ADD || hi_op !== ALU_ADC) begin n_errors++; $display("FAIL add16_ops: got %0d/%0d exp %0d/%0d", lo_op, hi_op, ALU_ADD, ALU_ADC); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL add16_done_pulse: got %b exp 0", done); end
        n_checks++; if (result !== 16'h1000 || out_flags !== 4'b1010) begin n_errors++; $display("FAIL add16_hold: got %h/%b exp 1000/1010", result, out_flags); end
        run_op(2'd0, 16'hFFFF, 16'h0001, 4'b0000, res, of, lat, own, lo_op, hi_op, hi_op2, hi_in);
        n_checks++; if (res !== 16'h0000) begin n_errors++; $display("FAIL add16_wrap_result: got %h exp 0000", res); end
        n_checks++; if (of !== 4'b0011) begin n_errors++; $display("FAIL add16_wrap_flags: got %b exp 0011", of); end
        n_checks++; if (hi_in !== 4'b0001) begin n_errors++; $display("FAIL add16_wrap_cin: got %b exp 0001", hi_in); end
    endtask

    task automatic test_incdec();
        logic [15:0] res; flags_t of; int lat; logic [7:0] own;
        alu_op_t lo_op, hi_op; data_t hi_op2; flags_t hi_in;
        run_op(2'd1, 16'hFFFF, 16'h1234, 4'b1101, res, of, lat, own, lo_op, hi_op, hi_op2, hi_in);
        n_checks++; if (res !== 16'h0000) begin n_errors++; $display("FAIL inc16_result: got %h exp 0000", res); end
        n_checks++; if (of !== 4'b1101) begin n_errors++; $display("FAIL inc16_flags: got %b exp 1101", of); end
        n_checks++; if (lo_op !== ALU_ADD || hi_op !== ALU_ADC) begin n_errors++; $display("FAIL inc16_ops: got %0d/%0d exp %0d/%0d", lo_op, hi_op, ALU_ADD, ALU_ADC); end
        run_op(2'd2, 16'h0000, 16'h5678, 4'b0110, res, of, lat, own, lo_op, hi_op, hi_op2, hi_in);
        n_checks++; if (res !== 16'hFFFF) begin n_errors++; $display("FAIL dec16_result: got %h exp ffff", res); end
        n_checks++; if (of !== 4'b0110) begin n_errors++; $display("FAIL dec16_flags: got %b exp 0110", of); end
        n_checks++; if (lo_op !== ALU_SUB || hi_op !== ALU_SBC) begin n_errors++; $display("FAIL dec16_ops: got %0d/%0d exp %0d/%0d", lo_op, hi_op, ALU_SUB, ALU_SBC); end
        n_checks++; if (hi_in !== 4'b0001 || hi_op2 !== 8'h00) begin n_errors++; $display("FAIL dec16_hi_drive: got cin=%b op2=%h exp 0001/00", hi_in, hi_op2); end
    endtask

    task automatic test_addsp();
        logic [15:0] res; flags_t of; int lat; logic [7:0] own;
        alu_op_t lo_op, hi_op; data_t hi_op2; flags_t hi_in;
        run_op(2'd3, 16'h000F, 16'h0001, 4'b1111, res, of, lat, own, lo_op, hi_op, hi_op2, hi_in);
        n_checks++; if (res !== 16'h0010) begin n_errors++; $display("FAIL addsp_pos_result: got %h exp 0010", res); end
        n_checks++; if (of !== 4'b0010) begin n_errors++; $display("FAIL addsp_pos_flags: got %b exp 0010", of); end
        run_op(2'd3, 16'h0000, 16'hABFF, 4'b0000, res, of, lat, own, lo_op, hi_op, hi_op2, hi_in);
        n_checks++; if (hi_op2 !== 8'hFF) begin n_errors++; $display("FAIL addsp_sext_op2: got %h exp ff", hi_op2); end
        n_checks++; if (res !== 16'hFFFF) begin n_errors++; $display("FAIL addsp_neg_result: got %h exp ffff", res); end
        n_checks++; if (of !== 4'b0000) begin n_errors++; $display("FAIL addsp_neg_flags: got %b exp 0000", of); end
        run_op(2'd3, 16'h1234, 16'h00FE, 4'b1000, res, of, lat, own, lo_op, hi_op, hi_op2, hi_in);
        n_checks++; if (res !== 16'h1232) begin n_errors++; $display("FAIL addsp_carry_result: got %h exp 1232", res); end
        n_checks++; if (of !== 4'b0011) begin n_errors++; $display("FAIL addsp_carry_flags: got %b exp 0011", of); end
    endtask

    task automatic test_back_to_back();
        logic [8:0] rdy, dn;
        logic [15:0] r1, r2;
        flags_t of2;
        rdy = '0; dn = '0; r1 = '0; r2 = '0; of2 = '0;
        @(negedge clk);
        req_valid = 1'b1; req_cmd = 2'd0; req_a = 16'h0001; req_b = 16'h0002; req_flags = 4'b0000;
        rdy[0] = req_ready; dn[0] = done;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin req_cmd = 2'd1; req_a = 16'h00FF; req_b = 16'h0000; req_flags = 4'b1000; end
            rdy[k] = req_ready; dn[k] = done;
            if (k == 3) r1 = result;
            if (k == 7) begin r2 = result; of2 = out_flags; end
            if (k == 5) req_valid = 1'b0;
        end
        n_checks++; if (rdy !== 9'b1_0001_0001) begin n_errors++; $display("FAIL b2b_ready: got %b exp 100010001", rdy); end
        n_checks++; if (dn !== 9'b0_1000_1000) begin n_errors++; $display("FAIL b2b_done: got %b exp 010001000", dn); end
        n_checks++; if (r1 !== 16'h0003) begin n_errors++; $display("FAIL b2b_first_result: got %h exp 0003", r1); end
        n_checks++; if (r2 !== 16'h0100 || of2 !== 4'b1000) begin n_errors++; $display("FAIL b2b_second: got %h/%b exp 0100/1000", r2, of2); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] res; flags_t of; int lat; logic [7:0] own;
        alu_op_t lo_op, hi_op; data_t hi_op2; flags_t hi_in;
        logic saw_done;
        saw_done = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_cmd = 2'd0; req_a = 16'h0FFF; req_b = 16'h0001; req_flags = 4'b1000;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (alu_own !== 1'b1 || alu_op !== ALU_ADC) begin n_errors++; $display("FAIL rstmid_in_hi: got own=%b op=%0d exp 1/%0d", alu_own, alu_op, ALU_ADC); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (alu_own !== 1'b0 || req_ready !== 1'b1 || done !== 1'b0) begin
            n_errors++; $display("FAIL rstmid_ctrl: got own=%b rdy=%b done=%b exp 0/1/0", alu_own, req_ready, done);
        end
        n_checks++; if (result !== 16'h0000 || out_flags !== 4'b0000) begin n_errors++; $display("FAIL rstmid_outputs: got %h/%b exp 0000/0000", result, out_flags); end
        n_checks++; if (alu_op !== ALU_LD1 || alu_op1 !== 8'h00 || alu_in_flags !== 4'b0000) begin n_errors++; $display("FAIL rstmid_alu_drive: got op=%0d op1=%h cin=%b", alu_op, alu_op1, alu_in_flags); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        n_checks++; if (saw_done !== 1'b0) begin n_errors++; $display("FAIL rstmid_no_done: got %b exp 0", saw_done); end
        run_op(2'd0, 16'hFFFF, 16'h0001, 4'b0000, res, of, lat, own, lo_op, hi_op, hi_op2, hi_in);
        n_checks++; if (lat !== 3 || res !== 16'h0000 || of !== 4'b0011) begin
            n_errors++; $display("FAIL rstmid_recover: got lat=%0d res=%h flags=%b exp 3/0000/0011", lat, res, of);
        end
    endtask

    initial begin
        rst_n = 1'b1; req_valid = 1'b0; req_cmd = 2'd0;
        req_a = '0; req_b = '0; req_flags = '0;
        test_reset();
        test_add16();
        test_incdec();
        test_addsp();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu16_seq.md
Name: alu16_seq

Overview:
- Sequences the shared 8-bit SM83 ALU over two consecutive cycles to execute the 16-bit operations: ADD HL,rr; INC rr; DEC rr; ADD SP,e8.
- Sits between the decoder/control unit and the ALU operand/op muxes.
- While busy it owns the ALU inputs and signals ownership so the control mux selects it.
- Returns a 16-bit result and the final flag set through a valid/ready request and a done pulse.

Parameters:
- None.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_cmd  input  2  0=ADD16, 1=INC16, 2=DEC16, 3=ADDSP
- req_a  input  16  first operand (HL or SP or rr)
- req_b  input  16  second operand (rr for ADD16; e8 in [7:0] for ADDSP, [15:8] ignored; unused otherwise)
- req_flags  input  flags_t  current F register
- alu_own  output  1  block is driving the ALU this cycle
- alu_op  output  alu_op_t  ALU operation
- alu_op1  output  data_t  ALU operand 1
- alu_op2  output  data_t  ALU operand 2
- alu_in_flags  output  flags_t  ALU carry-in source
- alu_result  input  data_t  ALU result (combinational, same cycle)
- alu_out_flags  input  flags_t  ALU flags (combinational, same cycle)
- done  output  1  one-cycle pulse, result/flags valid
- result  output  16  16-bit result
- out_flags  output  flags_t  flags to write back to F

Behaviour:
- Reset is asynchronous, active-low. On reset: state=IDLE, req_ready=1, alu_own=0, done=0, result=0, out_flags=0, all captured registers=0.
- FSM states:
  - IDLE: req_ready=1. On req_valid, capture cmd, a, b, flags; go to LO.
  - LO: alu_own=1, low byte. Register alu_result into res_lo and alu_out_flags into lo_flags. Go to HI.
  - HI: alu_own=1, high byte. Register alu_result into res_hi and alu_out_flags into hi_flags. Go to DONE.
  - DONE: done=1 for exactly one cycle; result={res_hi,res_lo}; out_flags per rules below. Go to IDLE.
- req_ready is 1 only in IDLE. A request arriving in any other state is not accepted; the requester holds it.
- Latency: accept at cycle 0, done at cycle 3. Maximum throughput is one op per 4 cycles.
- result and out_flags hold their value after done until the next DONE.
- Outside LO/HI: alu_own=0, alu_op=ALU_LD1, operands 0, alu_in_flags=0.
- LO drive per cmd (alu_op, op1, op2):
  - ADD16: ALU_ADD, a[7:0], b[7:0]
  - INC16: ALU_ADD, a[7:0], 8'h01
  - DEC16: ALU_SUB, a[7:0], 8'h01
  - ADDSP: ALU_ADD, a[7:0], b[7:0]
- HI drive per cmd (alu_op, op1, op2). In every case alu_in_flags.c = lo_flags.c and all other alu_in_flags bits are 0.
  - ADD16: ALU_ADC, a[15:8], b[15:8]
  - INC16: ALU_ADC, a[15:8], 8'h00
  - DEC16: ALU_SBC, a[15:8], 8'h00
  - ADDSP: ALU_ADC, a[15:8], {8{b[7]}} (sign extension)
- ALU_INC/ALU_DEC are never used here; ALU_DEC suppresses carry and would break propagation.
- Flag rules for out_flags:
  - ADD16: Z=req_flags.z, N=0, H=hi_flags.h, C=hi_flags.c
  - INC16, DEC16: out_flags=req_flags (F unchanged)
  - ADDSP: Z=0, N=0, H=lo_flags.h, C=lo_flags.c
- H is taken from the ALU as produced; this block does not recompute it.
- Wrap-around: 16-bit results are modulo 2^16; carry out of the high byte is reflected only through the flag rules above.
- Reset asserted mid-operation (LO/HI/DONE) aborts immediately: IDLE, done stays 0, captured request discarded.
- req_valid in the DONE cycle is not accepted; it is accepted the following IDLE cycle.

Test Plan:
- ADD16 a=0x0FFF, b=0x0001, req_flags.z=1 -> done at cycle 3, result=0x1000, Z=1, N=0, H=1, C=0; alu_own high cycles 1-2 only.
- ADD16 a=0xFFFF, b=0x0001, req_flags=0 -> result=0x0000, Z=0, N=0, H=1, C=1 (carry propagated via ADC).
- INC16 a=0xFFFF, req_flags={z=1,n=1,h=0,c=1} -> result=0x0000, out_flags equal req_flags. DEC16 a=0x0000 -> result=0xFFFF, flags unchanged, LO uses ALU_SUB and HI uses ALU_SBC with carry-in 1.
- ADDSP a=0x000F, b=0x0001 -> result=0x0010, Z=0, N=0, H=1, C=0. ADDSP a=0x0000, b=0x00FF -> HI op2=0xFF, result=0xFFFF, H=0, C=0.
- Back-to-back: req_valid held high for two requests -> req_ready low cycles 1-3; second accepted cycle 4, done cycles 3 and 7.
- Deassert rst_n during HI -> outputs return to reset values asynchronously, no done pulse; a new request after release completes normally.
